// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution front end: kernel size and stream FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnn_pkg;

    localparam int KERNEL_SIZE = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/line_shift_reg.sv
// One image row of delay: a DEPTH-deep, DATA_SIZE-wide shift register.
// Latency: dout is the value pushed DEPTH enabled cycles earlier.
// Backpressure: none; contents hold whenever en is low.
module line_shift_reg #(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [DATA_SIZE-1:0] din,
    output logic [DATA_SIZE-1:0] dout
);

    // Storage carries no reset; the parent never emits windows built from stale rows.
    logic [DATA_SIZE-1:0] mem [DEPTH];

    // Advance the whole row by one slot on each accepted pixel.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_line_buffer.sv
// Turns a raster pixel stream into 3x3 windows using two row-deep line buffers.
// Latency: window_valid/window_out one cycle after the pixel completing the window.
// Backpressure: en low stalls everything; no output side backpressure.
module conv_line_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic                                       en,
    input  logic [DATA_SIZE-1:0]                       pixel_in,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0] window_out,
    output logic                                       window_valid,
    output logic                                       busy,
    output logic                                       done
);

    localparam int CW    = $clog2(IMG_WIDTH);
    localparam int RW    = $clog2(IMG_HEIGHT);
    localparam int WIN_W = KERNEL_SIZE * KERNEL_SIZE * DATA_SIZE;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL_SIZE - 1);

    state_t               state;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [WIN_W-1:0]     win;
    logic [WIN_W-1:0]     win_nxt;
    logic [DATA_SIZE-1:0] lb0_out;
    logic [DATA_SIZE-1:0] lb1_out;
    logic                 accept;
    logic                 last_pix;
    logic                 emit;

    // Pixels only count while streaming; en is meaningless in IDLE and DONE.
    assign accept   = (state == STREAM) && en;
    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);
    assign emit     = accept && (row >= ROW_MIN) && (col >= COL_MIN);
    assign busy     = (state == STREAM);
    assign done     = (state == DONE);

    // lb0 yields the same column one row up, lb1 two rows up.
    line_shift_reg #(.DATA_SIZE(DATA_SIZE), .DEPTH(IMG_WIDTH)) u_line0 (
        .clk  (clk),
        .en   (accept),
        .din  (pixel_in),
        .dout (lb0_out)
    );

    line_shift_reg #(.DATA_SIZE(DATA_SIZE), .DEPTH(IMG_WIDTH)) u_line1 (
        .clk  (clk),
        .en   (accept),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    // Next window: shift every row one column left, new column enters on the right.
    always_comb begin
        win_nxt = win;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                win_nxt[DATA_SIZE*(KERNEL_SIZE*r+c) +: DATA_SIZE] =
                    win[DATA_SIZE*(KERNEL_SIZE*r+c+1) +: DATA_SIZE];
            end
        end
        win_nxt[DATA_SIZE*(KERNEL_SIZE*0+2) +: DATA_SIZE] = lb1_out;
        win_nxt[DATA_SIZE*(KERNEL_SIZE*1+2) +: DATA_SIZE] = lb0_out;
        win_nxt[DATA_SIZE*(KERNEL_SIZE*2+2) +: DATA_SIZE] = pixel_in;
    end

    // Frame sequencing: start is only honoured in IDLE, DONE lasts one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= STREAM;
                STREAM:  if (accept && last_pix) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Internal window shifts on every accepted pixel; the output copy only
    // updates when a complete window is available, so it holds otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win          <= '0;
            window_out   <= '0;
            window_valid <= 1'b0;
        end else begin
            window_valid <= emit;
            if (accept) win <= win_nxt;
            if (emit) window_out <= win_nxt;
        end
    end

endmodule

// File: tb/tb_conv_line_buffer.sv
module tb_conv_line_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        en;
    logic [7:0]  pixel_in;
    logic [71:0] window_out;
    logic        window_valid;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  trig;
        logic [71:0] win;
    } vec_t;

    vec_t exp_tbl [4];

    logic [71:0] got_win [$];
    logic [7:0]  got_trig [$];
    int          done_cnt;
    logic [7:0]  done_trig;
    logic        en_e;
    logic [7:0]  pix_e;

    conv_line_buffer #(.DATA_SIZE(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .en           (en),
        .pixel_in     (pixel_in),
        .window_out   (window_out),
        .window_valid (window_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] mk9(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Remember what was presented at each rising edge.
    always @(posedge clk) begin
        en_e  = en;
        pix_e = pixel_in;
    end

    // Collect windows and done pulses between edges.
    always @(negedge clk) begin
        if (window_valid) begin
            got_win.push_back(window_out);
            got_trig.push_back(pix_e);
            chk("valid_after_accept", 72'(en_e), 72'(1));
        end
        if (done) begin
            done_cnt++;
            done_trig = pix_e;
        end
    end

    task automatic clear_capture();
        got_win.delete();
        got_trig.delete();
        done_cnt  = 0;
        done_trig = 8'hxx;
    endtask

    task automatic run_frame(input string tag, input bit gap, input int start_at, input bit en99);
        clear_capture();
        start    = 1'b1;
        en       = en99;
        pixel_in = en99 ? 8'd99 : 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        en    = 1'b0;
        chk({tag, "_busy"}, 72'(busy), 72'(1));
        for (int i = 0; i < 16; i++) begin
            en       = 1'b1;
            pixel_in = 8'(i);
            start    = (i == start_at);
            @(posedge clk); #1;
            start = 1'b0;
            if (gap) begin
                en       = 1'b0;
                pixel_in = 8'hEE;
                @(posedge clk); #1;
            end
        end
        en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_nwin"}, 72'(got_win.size()), 72'(4));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_trig%0d", tag, k),
                72'((k < got_trig.size()) ? got_trig[k] : 8'hxx), 72'(exp_tbl[k].trig));
            chk($sformatf("%s_win%0d", tag, k),
                (k < got_win.size()) ? got_win[k] : 72'hx, exp_tbl[k].win);
        end
        chk({tag, "_done_cnt"}, 72'(done_cnt), 72'(1));
        chk({tag, "_done_when"}, 72'(done_trig), 72'(15));
        chk({tag, "_hold"}, window_out, exp_tbl[3].win);
        chk({tag, "_idle_busy"}, 72'(busy), 72'(0));
        chk({tag, "_idle_done"}, 72'(done), 72'(0));
    endtask

    initial begin
        exp_tbl[0] = '{trig: 8'd10, win: mk9(0, 1, 2, 4, 5, 6, 8, 9, 10)};
        exp_tbl[1] = '{trig: 8'd11, win: mk9(1, 2, 3, 5, 6, 7, 9, 10, 11)};
        exp_tbl[2] = '{trig: 8'd14, win: mk9(4, 5, 6, 8, 9, 10, 12, 13, 14)};
        exp_tbl[3] = '{trig: 8'd15, win: mk9(5, 6, 7, 9, 10, 11, 13, 14, 15)};

        reset    = 1'b0;
        start    = 1'b0;
        en       = 1'b0;
        pixel_in = 8'd0;
        clear_capture();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_window", window_out, 72'(0));
        chk("rst_valid", 72'(window_valid), 72'(0));
        chk("rst_busy", 72'(busy), 72'(0));
        chk("rst_done", 72'(done), 72'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        // en is ignored in IDLE: nothing should start without start.
        en = 1'b1;
        pixel_in = 8'd7;
        repeat (2) @(posedge clk);
        #1;
        en = 1'b0;
        chk("idle_no_busy", 72'(busy), 72'(0));

        run_frame("plain", 1'b0, -1, 1'b0);
        run_frame("gapped", 1'b1, -1, 1'b0);

        // Abort a frame with an asynchronous reset after pixel 9.
        clear_capture();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            en       = 1'b1;
            pixel_in = 8'(i);
            @(posedge clk); #1;
        end
        en = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", 72'(busy), 72'(0));
        chk("abort_valid", 72'(window_valid), 72'(0));
        chk("abort_window", window_out, 72'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        en       = 1'b1;
        pixel_in = 8'd10;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b0;
        chk("abort_no_win", 72'(got_win.size()), 72'(0));
        chk("abort_no_done", 72'(done_cnt), 72'(0));
        chk("abort_idle", 72'(busy), 72'(0));
        run_frame("after_abort", 1'b0, -1, 1'b0);

        run_frame("midstart", 1'b0, 6, 1'b0);
        run_frame("start_en", 1'b0, -1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
